i2c_req_arbiter: RTL and testbench
==================================

Name: i2c_req_arbiter

Overview:
- Shares one i2c_master between N_REQ independent requesters using round-robin arbitration.
- Accepts a latched single-byte transaction (addr, rw, tx byte) from each requester and sequences the master's start/busy handshake.
- Returns rx data and status to the granted requester only, with a watchdog that recovers from a hung bus.
- Sits between the register/sensor-poll logic and i2c_master; drives all master control inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1_000_000, clk cycles allowed per phase (start-accept or completion) before abort.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  level request; held until done[i]
- req_addr  in  7*N_REQ  7-bit slave address per requester; slice i = [7i+6:7i]
- req_tx  in  8*N_REQ  write byte per requester; slice i = [8i+7:8i]
- req_rw  in  N_REQ  0 write, 1 read
- gnt  out  N_REQ  one-hot current owner; zero when idle
- done  out  N_REQ  one-clk pulse to owner at transaction end
- rsp_rx_byte  out  8  read data; valid with done pulse
- rsp_ack_err  out  1  master ack_error; valid with done pulse
- rsp_timeout  out  1  watchdog abort; valid with done pulse
- m_start  out  1  to master start
- m_addr  out  7  to master addr
- m_tx_byte  out  8  to master tx_byte
- m_rw  out  1  to master rw
- m_rx_byte  in  8  from master rx_byte
- m_busy  in  1  from master busy
- m_ack_error  in  1  from master ack_error

Behaviour:
- Reset (async, rst_n=0): state IDLE, gnt=0, done=0, m_start=0, m_addr=0, m_tx_byte=0, m_rw=0, rsp_*=0, rr pointer=0, watchdog=0. Reset mid-transaction abandons it silently; no done is issued.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE: if any req bit set and m_busy=0, pick the first set bit at or after rr_ptr (wrapping modulo N_REQ). Register gnt, then copy that requester's addr/tx/rw into the m_* outputs. Assert m_start and go to ISSUE. Issue takes 1 clk from request sampling to m_start high.
- ISSUE: hold m_start and the m_* fields stable until m_busy=1, then drop m_start and go to WAIT_DONE. The master samples start only on its internal tick, so holding is mandatory.
- WAIT_DONE: on m_busy 1->0, latch m_rx_byte (zero for writes) and m_ack_error, set rsp_timeout=0, then go to RESP.
- RESP: drive done[owner]=1 for exactly 1 clk with rsp_* valid. Set rr_ptr=owner+1 (wrapping), clear gnt, and return to IDLE. rsp_* hold their values until the next RESP.
- Watchdog: counter clears on entry to ISSUE and to WAIT_DONE and increments each clk in those states. On reaching TIMEOUT_CYCLES, set m_start=0, rsp_timeout=1, rsp_ack_err=1, rsp_rx_byte=0, then go to RESP. After a timeout, IDLE also waits for m_busy=0 before the next issue.
- Fields are sampled once at grant. Requester changes to req_* while granted are ignored.
- req[i] dropping while granted does not abort; done still pulses.
- A requester re-asserting immediately after done is served only after every other pending requester (fairness).
- Simultaneous requests: lowest index at or after rr_ptr wins. No requester waits more than N_REQ-1 transactions.
- gnt is never multi-hot. done is asserted only for the bit set in gnt.

Decomposition:
- Shared package i2c_pkg holds:
  - state_t enum (IDLE, ISSUE, WAIT_DONE, RESP);
  - I2C_ADDR_W=7, I2C_DATA_W=8;
  - a packed struct i2c_req_t {addr, tx, rw} reused by future i2c blocks.
- One sub-module: rr_arbiter (N_REQ, inputs req and ptr, output one-hot grant), purely combinational priority rotate. The top holds the FSM, watchdog and response registers.

Test Plan:
- Single write: req[0] with addr=0x50, tx=0xA5, rw=0 -> m_start held until m_busy rises, gnt=0001, exactly one done[0] pulse, rsp_ack_err=0 when the slave model ACKs.
- Single read: req[2] with addr=0x68, rw=1, slave returns 0x3C -> done[2] pulse with rsp_rx_byte=0x3C, rsp_ack_err=0, rsp_timeout=0.
- Contention: req=1111 asserted simultaneously after reset -> grant order 0,1,2,3. With req[0] re-asserted during its done, the next grant order is 1,2,3,0.
- NACK: slave model withholds the address ACK -> done with rsp_ack_err=1, rsp_timeout=0. Arbitration continues normally afterwards.
- Hang: m_busy forced to 1 indefinitely, TIMEOUT_CYCLES=64 -> done pulse 64 clks after WAIT_DONE entry with rsp_timeout=1. No new m_start while m_busy=1.
- Reset mid-transfer: rst_n low during WAIT_DONE -> all outputs zero immediately (async). After release, a fresh req[1] is granted first and no stale done is issued.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared i2c types: FSM states, field widths and the single-byte request record.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_t;

  typedef struct packed {
    logic [I2C_ADDR_W-1:0] addr;
    logic [I2C_DATA_W-1:0] tx;
    logic                  rw;
  } i2c_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  // Scan from the farthest offset back to ptr so the nearest requester wins last.
  always_comb begin
    int j;
    grant = '0;
    j     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N_REQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin sharing of one i2c_master among N_REQ requesters, with a
// per-phase watchdog that aborts a hung start or transfer.
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req,
  input  logic [I2C_ADDR_W*N_REQ-1:0]   req_addr,
  input  logic [I2C_DATA_W*N_REQ-1:0]   req_tx,
  input  logic [N_REQ-1:0]              req_rw,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              done,
  output logic [I2C_DATA_W-1:0]         rsp_rx_byte,
  output logic                          rsp_ack_err,
  output logic                          rsp_timeout,
  output logic                          m_start,
  output logic [I2C_ADDR_W-1:0]         m_addr,
  output logic [I2C_DATA_W-1:0]         m_tx_byte,
  output logic                          m_rw,
  input  logic [I2C_DATA_W-1:0]         m_rx_byte,
  input  logic                          m_busy,
  input  logic                          m_ack_error
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t                r_state, w_next;
  logic [N_REQ-1:0]      r_gnt;
  logic [PTR_W-1:0]      r_ptr;
  logic [WD_W-1:0]       r_wd;
  i2c_req_t              r_req;
  logic                  r_start;
  logic [I2C_DATA_W-1:0] r_rx;
  logic                  r_ack_err;
  logic                  r_timeout;

  logic [N_REQ-1:0]      w_arb_gnt;
  i2c_req_t              w_sel;
  logic [PTR_W-1:0]      w_owner;
  logic                  w_wd_hit;

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr (
    .req   (req),
    .ptr   (r_ptr),
    .grant (w_arb_gnt)
  );

  // Mux the winning requester's fields; sampled only once, at grant.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_arb_gnt[i]) begin
        w_sel.addr = req_addr[I2C_ADDR_W*i +: I2C_ADDR_W];
        w_sel.tx   = req_tx[I2C_DATA_W*i +: I2C_DATA_W];
        w_sel.rw   = req_rw[i];
      end
    end
  end

  // Encode the current one-hot owner for the pointer advance.
  always_comb begin
    w_owner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_gnt[i]) w_owner = PTR_W'(i);
    end
  end

  assign w_wd_hit = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: issue only to an idle master, leave a phase on handshake or watchdog.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (|req && !m_busy)       w_next = ISSUE;
      ISSUE:     if (m_busy || w_wd_hit)    w_next = (m_busy) ? WAIT_DONE : RESP;
      WAIT_DONE: if (!m_busy || w_wd_hit)   w_next = RESP;
      RESP:                                 w_next = IDLE;
      default:                              w_next = IDLE;
    endcase
  end

  // Grant, master fields, watchdog and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt     <= '0;
      r_ptr     <= '0;
      r_wd      <= '0;
      r_req     <= '0;
      r_start   <= 1'b0;
      r_rx      <= '0;
      r_ack_err <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_next == ISSUE) begin
            r_gnt   <= w_arb_gnt;
            r_req   <= w_sel;
            r_start <= 1'b1;
            r_wd    <= '0;
          end
        end
        ISSUE: begin
          if (m_busy) begin
            r_start <= 1'b0;
            r_wd    <= '0;
          end else if (w_wd_hit) begin
            r_start   <= 1'b0;
            r_timeout <= 1'b1;
            r_ack_err <= 1'b1;
            r_rx      <= '0;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        WAIT_DONE: begin
          // Completion wins over a watchdog hit landing on the same cycle.
          if (!m_busy) begin
            r_rx      <= r_req.rw ? m_rx_byte : '0;
            r_ack_err <= m_ack_error;
            r_timeout <= 1'b0;
          end else if (w_wd_hit) begin
            r_start   <= 1'b0;
            r_timeout <= 1'b1;
            r_ack_err <= 1'b1;
            r_rx      <= '0;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        RESP: begin
          r_gnt <= '0;
          r_ptr <= (w_owner == PTR_W'(N_REQ - 1)) ? '0 : w_owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign done        = (r_state == RESP) ? r_gnt : '0;
  assign rsp_rx_byte = r_rx;
  assign rsp_ack_err = r_ack_err;
  assign rsp_timeout = r_timeout;
  assign m_start     = r_start;
  assign m_addr      = r_req.addr;
  assign m_tx_byte   = r_req.tx;
  assign m_rw        = r_req.rw;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: behavioural i2c_master stand-in, round-robin
// reference model and scenario tasks run in sequence.
module tb_i2c_req_arbiter;

  localparam int N = 4;
  localparam int T = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_tx = '0;
  logic [N-1:0]   req_rw = '0;
  logic [N-1:0]   gnt, done;
  logic [7:0]     rsp_rx_byte;
  logic           rsp_ack_err, rsp_timeout;
  logic           m_start;
  logic [6:0]     m_addr;
  logic [7:0]     m_tx_byte;
  logic           m_rw;
  logic [7:0]     m_rx_byte = '0;
  logic           m_busy = 1'b0;
  logic           m_ack_error = 1'b0;

  always #5 clk = ~clk;

  i2c_req_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_tx(req_tx),
    .req_rw(req_rw), .gnt(gnt), .done(done), .rsp_rx_byte(rsp_rx_byte),
    .rsp_ack_err(rsp_ack_err), .rsp_timeout(rsp_timeout), .m_start(m_start),
    .m_addr(m_addr), .m_tx_byte(m_tx_byte), .m_rw(m_rw), .m_rx_byte(m_rx_byte),
    .m_busy(m_busy), .m_ack_error(m_ack_error)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave/master behaviour knobs, set by the scenario tasks.
  int         slv_lat = 0;
  int         slv_len = 3;
  logic       slv_nack = 1'b0;
  logic [7:0] slv_rx = '0;
  logic       slv_hang = 1'b0;

  // Captured by the master model.
  logic [6:0] cap_addr;
  logic [7:0] cap_tx;
  logic       cap_rw;
  int         busy_cyc = 0;
  int         hold_bad = 0;
  int         mst_st = 0;
  int         lat_cnt = 0;
  int         len_cnt = 0;

  // Master stand-in: takes start after slv_lat ticks, stays busy slv_len ticks.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      mst_st = 0;
    end else begin
      case (mst_st)
        0: if (m_start) begin
          cap_addr = m_addr; cap_tx = m_tx_byte; cap_rw = m_rw;
          lat_cnt = 0;
          mst_st = 1;
        end
        default: ;
      endcase
      if (mst_st == 1) begin
        if (!m_start || m_addr !== cap_addr || m_tx_byte !== cap_tx || m_rw !== cap_rw)
          hold_bad++;
        if (lat_cnt >= slv_lat) begin
          m_busy = 1'b1; m_rx_byte = slv_rx; m_ack_error = slv_nack;
          busy_cyc = cyc; len_cnt = 0; mst_st = 2;
        end else lat_cnt++;
      end else if (mst_st == 2 && !slv_hang) begin
        len_cnt++;
        if (len_cnt >= slv_len) begin
          m_busy = 1'b0;
          mst_st = 0;
        end
      end
    end
  end

  // Invariant monitors.
  int mon_multi = 0, mon_done_bad = 0, mon_done_long = 0;
  logic [N-1:0] prev_done = '0;
  always @(negedge clk) begin
    if ($countones(gnt) > 1) mon_multi++;
    if ((done & ~gnt) != '0 || $countones(done) > 1) mon_done_bad++;
    if (done != '0 && prev_done != '0) mon_done_long++;
    prev_done = done;
  end

  // Reference model state: rotating pointer and each requester's latched fields.
  int         model_ptr = 0;
  logic [6:0] f_addr [N];
  logic [7:0] f_tx   [N];
  logic       f_rw   [N];

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] t, input logic rw);
    f_addr[i] = a; f_tx[i] = t; f_rw[i] = rw;
    req_addr[7*i +: 7] = a;
    req_tx[8*i +: 8]   = t;
    req_rw[i]          = rw;
    req[i]             = 1'b1;
  endtask

  task automatic wait_done(output int idx, output logic [7:0] rx, output logic ack,
                           output logic to, output bit got);
    idx = -1; rx = '0; ack = 1'b0; to = 1'b0; got = 1'b0;
    for (int k = 0; k < 5000 && !got; k++) begin
      @(negedge clk);
      if (done != '0) begin
        got = 1'b1;
        for (int i = 0; i < N; i++) if (done[i]) idx = i;
        rx = rsp_rx_byte; ack = rsp_ack_err; to = rsp_timeout;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({gnt, done, m_start, m_addr, m_tx_byte, m_rw, rsp_rx_byte, rsp_ack_err, rsp_timeout} !== '0) begin
      bad++; $display("FAIL reset_outputs got gnt=%b done=%b start=%b addr=%h want all zero", gnt, done, m_start, m_addr);
    end
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_single_write();
    int idx; logic [7:0] rx; logic ack, to; bit got; bit seen;
    slv_lat = 3; slv_len = 4; slv_nack = 1'b0; slv_rx = 8'h77; slv_hang = 1'b0;
    @(negedge clk);
    set_req(0, 7'h50, 8'hA5, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = m_start;
    end
    total++;
    if (!seen || gnt !== 4'b0001) begin bad++; $display("FAIL wr_gnt got=%b start=%0d want=0001", gnt, seen); end
    req_addr[6:0] = 7'h11;  // change while granted must be ignored
    wait_done(idx, rx, ack, to, got);
    req[0] = 1'b0;
    total++; if (!got || idx != 0) begin bad++; $display("FAIL wr_done_idx got=%0d want=0", idx); end
    total++; if (cap_addr !== 7'h50) begin bad++; $display("FAIL wr_addr got=%h want=50", cap_addr); end
    total++; if (cap_tx !== 8'hA5 || cap_rw !== 1'b0) begin bad++; $display("FAIL wr_tx got=%h rw=%b want=a5/0", cap_tx, cap_rw); end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL wr_start_hold got=%0d want=0", hold_bad); end
    total++; if ({rx, ack, to} !== 10'b0) begin bad++; $display("FAIL wr_rsp got rx=%h ack=%b to=%b want 0/0/0", rx, ack, to); end
    @(negedge clk);
    total++; if (done !== '0) begin bad++; $display("FAIL wr_done_pulse got=%b want=0000", done); end
    model_ptr = 1;
  endtask

  task automatic test_single_read();
    int idx, exp; logic [7:0] rx; logic ack, to; bit got;
    slv_lat = 1; slv_len = 3; slv_rx = 8'h3C; slv_nack = 1'b0;
    set_req(2, 7'h68, 8'h00, 1'b1);
    exp = pick(req, model_ptr);
    repeat (3) @(negedge clk);
    req[2] = 1'b0;  // dropping while granted must not abort
    wait_done(idx, rx, ack, to, got);
    total++; if (!got || idx != exp) begin bad++; $display("FAIL rd_done_idx got=%0d want=%0d", idx, exp); end
    total++; if (cap_addr !== 7'h68 || cap_rw !== 1'b1) begin bad++; $display("FAIL rd_addr got=%h rw=%b want=68/1", cap_addr, cap_rw); end
    total++; if (rx !== 8'h3C || ack !== 1'b0 || to !== 1'b0) begin bad++; $display("FAIL rd_rsp got rx=%h ack=%b to=%b want 3c/0/0", rx, ack, to); end
    model_ptr = (exp + 1) % N;
  endtask

  task automatic test_contention();
    int idx; logic [7:0] rx; logic ack, to; bit got;
    int ord [5] = '{0, 1, 2, 3, 0};
    do_reset();
    slv_lat = 0; slv_len = 2; slv_nack = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 7'(8'h10 + i), 8'(8'hC0 + i), 1'b0);
    for (int n = 0; n < 5; n++) begin
      wait_done(idx, rx, ack, to, got);
      total++;
      if (!got || idx != ord[n] || cap_addr !== f_addr[ord[n]]) begin
        bad++; $display("FAIL contention_order[%0d] got=%0d addr=%h want=%0d addr=%h", n, idx, cap_addr, ord[n], f_addr[ord[n]]);
      end
      if (idx >= 0) req[idx] = 1'b0;
      if (n == 0) set_req(0, 7'h20, 8'h5E, 1'b0);
    end
    model_ptr = 1;
  endtask

  task automatic test_nack();
    int idx, exp; logic [7:0] rx; logic ack, to; bit got;
    slv_nack = 1'b1; slv_rx = 8'hFF;
    set_req(3, 7'h2A, 8'h01, 1'b0);
    exp = pick(req, model_ptr);
    wait_done(idx, rx, ack, to, got);
    req[3] = 1'b0;
    total++; if (!got || idx != exp || ack !== 1'b1 || to !== 1'b0) begin
      bad++; $display("FAIL nack_rsp got idx=%0d ack=%b to=%b want %0d/1/0", idx, ack, to, exp);
    end
    model_ptr = (exp + 1) % N;
    slv_nack = 1'b0;
    set_req(1, 7'h2B, 8'h02, 1'b0);
    exp = pick(req, model_ptr);
    wait_done(idx, rx, ack, to, got);
    req[1] = 1'b0;
    total++; if (!got || idx != exp || ack !== 1'b0 || to !== 1'b0) begin
      bad++; $display("FAIL nack_recover got idx=%0d ack=%b to=%b want %0d/0/0", idx, ack, to, exp);
    end
    model_ptr = (exp + 1) % N;
  endtask

  task automatic test_hang();
    int idx, exp, dcyc, nstart; logic [7:0] rx; logic ack, to; bit got;
    slv_hang = 1'b1; slv_lat = 0; slv_len = 3; slv_rx = 8'h99;
    set_req(2, 7'h44, 8'h12, 1'b1);
    exp = pick(req, model_ptr);
    wait_done(idx, rx, ack, to, got);
    dcyc = cyc;
    req[2] = 1'b0;
    total++; if (!got || idx != exp || to !== 1'b1 || ack !== 1'b1 || rx !== 8'h00) begin
      bad++; $display("FAIL hang_rsp got idx=%0d to=%b ack=%b rx=%h want %0d/1/1/00", idx, to, ack, rx, exp);
    end
    // busy rises one clock before WAIT_DONE entry; done is T clocks after entry
    total++; if (dcyc - busy_cyc != T + 1) begin bad++; $display("FAIL hang_latency got=%0d want=%0d", dcyc - busy_cyc, T + 1); end
    model_ptr = (exp + 1) % N;
    set_req(1, 7'h45, 8'h00, 1'b1);
    nstart = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_start || gnt != '0) nstart++;
    end
    total++; if (nstart != 0) begin bad++; $display("FAIL hang_no_issue got=%0d want=0", nstart); end
    slv_rx = 8'h5A;
    slv_hang = 1'b0;
    exp = pick(req, model_ptr);
    wait_done(idx, rx, ack, to, got);
    req[1] = 1'b0;
    total++; if (!got || idx != exp || rx !== 8'h5A || ack !== 1'b0 || to !== 1'b0) begin
      bad++; $display("FAIL hang_recover got idx=%0d rx=%h ack=%b to=%b want %0d/5a/0/0", idx, rx, ack, to, exp);
    end
    model_ptr = (exp + 1) % N;
  endtask

  task automatic test_reset_mid();
    int idx, exp; logic [7:0] rx; logic ack, to; bit got; bit seen;
    slv_lat = 0; slv_len = 30;
    set_req(3, 7'h33, 8'h44, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = m_busy;
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0; req = '0;
    #1;
    total++;
    if (!seen || {gnt, done, m_start, m_addr, m_tx_byte, m_rw, rsp_rx_byte, rsp_ack_err, rsp_timeout} !== '0) begin
      bad++; $display("FAIL reset_mid got busy_seen=%0d gnt=%b addr=%h rx=%h want zeros", seen, gnt, m_addr, rsp_rx_byte);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    slv_len = 3;
    set_req(1, 7'h61, 8'h11, 1'b0);
    set_req(3, 7'h63, 8'h33, 1'b0);
    exp = pick(req, model_ptr);
    wait_done(idx, rx, ack, to, got);
    req[1] = 1'b0;
    total++; if (!got || idx != exp || exp != 1) begin bad++; $display("FAIL reset_mid_first got=%0d want=1", idx); end
    model_ptr = (exp + 1) % N;
    exp = pick(req, model_ptr);
    wait_done(idx, rx, ack, to, got);
    req[3] = 1'b0;
    total++; if (!got || idx != exp || cap_addr !== 7'h63) begin bad++; $display("FAIL reset_mid_second got=%0d addr=%h want=%0d addr=63", idx, cap_addr, exp); end
    model_ptr = (exp + 1) % N;
  endtask

  task automatic test_random();
    int idx, exp, nbad; logic [7:0] rx, exp_rx; logic ack, to, exp_ack; bit got;
    nbad = 0;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if ($urandom_range(0, 1) == 1) set_req(i, 7'($urandom), 8'($urandom), 1'($urandom));
    if (req == '0) set_req(int'($urandom_range(0, N - 1)), 7'($urandom), 8'($urandom), 1'b1);
    for (int n = 0; n < 40; n++) begin
      slv_lat = int'($urandom_range(0, 3)); slv_len = int'($urandom_range(1, 6));
      slv_nack = ($urandom_range(0, 3) == 0); slv_rx = 8'($urandom);
      exp = pick(req, model_ptr);
      exp_rx = f_rw[exp] ? slv_rx : 8'h00;
      exp_ack = slv_nack;
      wait_done(idx, rx, ack, to, got);
      total++;
      if (!got || idx != exp || cap_addr !== f_addr[exp] || cap_tx !== f_tx[exp] || cap_rw !== f_rw[exp]) begin
        bad++; nbad++;
        $display("FAIL rnd_grant[%0d] got idx=%0d addr=%h tx=%h want idx=%0d addr=%h tx=%h", n, idx, cap_addr, cap_tx, exp, f_addr[exp], f_tx[exp]);
      end
      total++;
      if (rx !== exp_rx || ack !== exp_ack || to !== 1'b0) begin
        bad++; nbad++;
        $display("FAIL rnd_rsp[%0d] got rx=%h ack=%b to=%b want rx=%h ack=%b to=0", n, rx, ack, to, exp_rx, exp_ack);
      end
      if (nbad > 6) break;
      model_ptr = (exp + 1) % N;
      req[exp] = 1'b0;
      if (idx >= 0) req[idx] = 1'b0;
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 2) == 0) set_req(i, 7'($urandom), 8'($urandom), 1'($urandom));
      if (req == '0) set_req(int'($urandom_range(0, N - 1)), 7'($urandom), 8'($urandom), 1'($urandom));
    end
    req = '0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_invariants();
    total++; if (mon_multi != 0) begin bad++; $display("FAIL gnt_onehot got=%0d want=0", mon_multi); end
    total++; if (mon_done_bad != 0) begin bad++; $display("FAIL done_owner got=%0d want=0", mon_done_bad); end
    total++; if (mon_done_long != 0) begin bad++; $display("FAIL done_width got=%0d want=0", mon_done_long); end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL start_hold got=%0d want=0", hold_bad); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_nack();
    test_hang();
    test_reset_mid();
    test_random();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
